// File: rtl/ej32_pkg.sv
// Shared types and constants for the EJ32 memory-mapped I/O blocks.
// The even-parity helper is used by ej32_obuf_tx when EJ32_TX_PARITY_EN is defined.
package ej32_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    // Default windows, shared with the LS unit address map
    localparam int unsigned OBUF_BASE = 32'h0000_1400;
    localparam int unsigned OBUF_SIZE = 32'h0000_0400;
    localparam int unsigned TIB_BASE  = 32'h0000_1000;
    localparam int unsigned TIB_SIZE  = 32'h0000_0400;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ej32_fifo.sv
// Parameterized synchronous FIFO with wrap-bit pointers; full/empty/count come
// straight from the pointer registers.
module ej32_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;
    logic [DW-1:0] mem_r [DEPTH];
    logic          do_pop_s;
    logic          do_push_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
    assign count     = wptr_r - rptr_r;
    assign do_pop_s  = pop && !empty;
    // A pop in the same edge frees a slot, so a push is accepted even when full
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rptr_r[AW-1:0]];

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Storage array (contents need no reset; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ej32_obuf_tx.sv
// Snoops byte writes into the OBUF window, queues them and sends them as UART
// frames (8N1; 8E1 when EJ32_TX_PARITY_EN is defined).
module ej32_obuf_tx
    import ej32_pkg::*;
#(
    parameter int unsigned OBUF    = OBUF_BASE,
    parameter int unsigned OBUF_SZ = OBUF_SIZE,
    parameter int unsigned ASZ     = 17,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CLK_DIV = 868
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ls_asel,
    input  logic [ASZ-1:0]          ls_addr,
    input  logic [7:0]              data,
    input  logic                    dwe,
    output logic                    tx_o,
    output logic                    full_o,
    output logic                    busy_o,
    output logic                    ovf_o,
    output logic [$clog2(DEPTH):0]  cnt_o
);

    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0]  BCNT_TOP  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0]  BCNT_ONE  = BW'(1);
    localparam logic [BW-1:0]  BCNT_ZERO = BW'(0);
    localparam logic [ASZ:0]   WIN_LO    = (ASZ+1)'(OBUF);
    localparam logic [ASZ:0]   WIN_HI    = (ASZ+1)'(OBUF + OBUF_SZ);

    tx_state_t     state_r, state_n;
    logic [BW-1:0] bcnt_r, bcnt_n;
    logic [2:0]    bidx_r, bidx_n;
    logic [7:0]    shift_r, shift_n;
    logic          tx_r, tx_n;
    logic          ovf_r;
    logic          hit_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [7:0]    fifo_dout_s;

    // One extra address bit keeps the upper bound exact when the window ends at the top
    assign hit_s = dwe && ls_asel && ({1'b0, ls_addr} >= WIN_LO) && ({1'b0, ls_addr} < WIN_HI);
    assign pop_s = (state_r == TX_IDLE) && !empty_s;

    ej32_fifo #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hit_s),
        .pop   (pop_s),
        .din   (data),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .count (cnt_o)
    );

`ifdef EJ32_TX_PARITY_EN
    logic par_r;

    // Parity of the byte being sent, captured when it leaves the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (pop_s) begin
            par_r <= even_parity(fifo_dout_s);
        end
    end
`endif

    // Frame sequencing: next state, baud counter, bit index and shift register
    always_comb begin
        state_n = state_r;
        bcnt_n  = bcnt_r;
        bidx_n  = bidx_r;
        shift_n = shift_r;
        case (state_r)
            TX_IDLE: begin
                if (pop_s) begin
                    state_n = TX_START;
                    bcnt_n  = BCNT_TOP;
                    shift_n = fifo_dout_s;
                end else begin
                    state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (bcnt_r == BCNT_ZERO) begin
                    state_n = TX_DATA;
                    bcnt_n  = BCNT_TOP;
                    bidx_n  = 3'd0;
                end else begin
                    bcnt_n = bcnt_r - BCNT_ONE;
                end
            end
            TX_DATA: begin
                if (bcnt_r == BCNT_ZERO) begin
                    bcnt_n = BCNT_TOP;
                    if (bidx_r == 3'd7) begin
`ifdef EJ32_TX_PARITY_EN
                        state_n = TX_PAR;
`else
                        state_n = TX_STOP;
`endif
                    end else begin
                        shift_n = {1'b0, shift_r[7:1]};
                        bidx_n  = bidx_r + 3'd1;
                    end
                end else begin
                    bcnt_n = bcnt_r - BCNT_ONE;
                end
            end
`ifdef EJ32_TX_PARITY_EN
            TX_PAR: begin
                if (bcnt_r == BCNT_ZERO) begin
                    state_n = TX_STOP;
                    bcnt_n  = BCNT_TOP;
                end else begin
                    bcnt_n = bcnt_r - BCNT_ONE;
                end
            end
`endif
            TX_STOP: begin
                if (bcnt_r == BCNT_ZERO) begin
                    state_n = TX_IDLE;
                end else begin
                    bcnt_n = bcnt_r - BCNT_ONE;
                end
            end
            default: begin
                state_n = TX_IDLE;
                bcnt_n  = BCNT_ZERO;
                bidx_n  = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming cycle, registered below so tx_o is glitch-free
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            TX_IDLE:  tx_n = 1'b1;
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = shift_n[0];
`ifdef EJ32_TX_PARITY_EN
            TX_PAR:   tx_n = par_r;
`endif
            TX_STOP:  tx_n = 1'b1;
            default:  tx_n = 1'b1;
        endcase
    end

    // FSM and line registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TX_IDLE;
            bcnt_r  <= BCNT_ZERO;
            bidx_r  <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            bcnt_r  <= bcnt_n;
            bidx_r  <= bidx_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
        end
    end

    // Sticky overflow: a window write that found no free slot
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (hit_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign tx_o   = tx_r;
    assign ovf_o  = ovf_r;
    assign full_o = full_s;
    assign busy_o = !empty_s || (state_r != TX_IDLE);

endmodule

// File: tb/tb_ej32_obuf_tx.sv
// Directed bench for ej32_obuf_tx (DEPTH=4, CLK_DIV=4); a background UART
// monitor decodes tx_o into a byte queue. Honors EJ32_TX_PARITY_EN.
module tb_ej32_obuf_tx;

    localparam int unsigned DIV = 4;
    localparam int unsigned DEP = 4;
`ifdef EJ32_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_asel = 1'b0;
    logic [16:0] ls_addr = 17'h0;
    logic [7:0]  data = 8'h00;
    logic        dwe = 1'b0;
    logic        tx_o, full_o, busy_o, ovf_o;
    logic [2:0]  cnt_o;

    int checks = 0;
    int errors = 0;
    int frame_err = 0;
    int rst_epoch = 0;
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];

    always #5 clk = ~clk;

    ej32_obuf_tx #(
        .OBUF    (32'h1400),
        .OBUF_SZ (32'h0400),
        .ASZ     (17),
        .DEPTH   (DEP),
        .CLK_DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ls_asel (ls_asel),
        .ls_addr (ls_addr),
        .data    (data),
        .dwe     (dwe),
        .tx_o    (tx_o),
        .full_o  (full_o),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o),
        .cnt_o   (cnt_o)
    );

    always @(posedge clk) begin
        if (rst) rst_epoch <= rst_epoch + 1;
    end

    // UART receiver: samples each bit near its centre; frames cut by reset are dropped
    initial begin : uart_mon
        logic [7:0] b;
        logic       p;
        logic       ok;
        int         ep;
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                ep = rst_epoch;
                ok = 1'b1;
                p  = 1'b0;
                repeat (DIV/2) @(negedge clk);
                if (tx_o !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clk);
                    b[k] = tx_o;
                end
`ifdef EJ32_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                p = tx_o;
`endif
                repeat (DIV) @(negedge clk);
                if (tx_o !== 1'b1) ok = 1'b0;
                if (ep == rst_epoch) begin
                    if (ok) begin
                        rx_q.push_back(b);
                        rx_par_q.push_back(p);
                    end else begin
                        frame_err++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [16:0] a, input logic [7:0] d, input logic as);
        ls_addr = a;
        data    = d;
        ls_asel = as;
        dwe     = 1'b1;
        tick();
        dwe     = 1'b0;
        ls_asel = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (busy_o !== 1'b0 && t < budget) begin
            tick();
            t++;
        end
        check(tag, busy_o, 0);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input logic p);
        logic pr;
        if (rx_q.size() > 0) begin
            check(tag, rx_q.pop_front(), b);
            pr = rx_par_q.pop_front();
`ifdef EJ32_TX_PARITY_EN
            check({tag, "_par"}, pr, p);
`endif
        end
    endtask

    initial begin : main
        logic [7:0] b;
        logic       exp_line [NBITS];
        int         lows;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ovf", ovf_o, 0);

        // Idle with no writes
        lows = 0;
        repeat (1000) begin
            tick();
            if (tx_o !== 1'b1) lows++;
        end
        check("idle_tx_lows", lows, 0);
        check("idle_busy", busy_o, 0);
        check("idle_cnt", cnt_o, 0);

        // Single write 'h41: line 0,1,0,0,0,0,0,1,0,(par 0),1
        b = 8'h41;
        exp_line[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_line[k+1] = b[k];
`ifdef EJ32_TX_PARITY_EN
        exp_line[9] = 1'b0;
`endif
        exp_line[NBITS-1] = 1'b1;
        wr(17'h1400, b, 1'b1);
        check("w1_cnt_after_write", cnt_o, 1);
        check("w1_tx_after_write", tx_o, 1);
        check("w1_busy_after_write", busy_o, 1);
        tick();
        check("w1_cnt_after_pop", cnt_o, 0);
        for (int k = 0; k < NBITS; k++) begin
            if (k > 0) repeat (DIV) tick();
            check($sformatf("w1_bit%0d", k), tx_o, exp_line[k]);
        end
        repeat (DIV - 1) tick();
        check("w1_busy_last_clk", busy_o, 1);
        tick();
        check("w1_busy_done", busy_o, 0);
        check("w1_tx_done", tx_o, 1);
        wait_rx("w1_rx_count", 1, 10);
        expect_byte("w1_rx_byte", 8'h41, 1'b0);

        // Window bounds
        wr(17'h13FF, 8'h11, 1'b1);
        check("win_below_cnt", cnt_o, 0);
        wr(17'h1800, 8'h22, 1'b1);
        check("win_above_cnt", cnt_o, 0);
        wr(17'h1400, 8'h33, 1'b0);
        check("win_noasel_cnt", cnt_o, 0);
        check("win_noasel_busy", busy_o, 0);
        wr(17'h17FF, 8'h5A, 1'b1);
        check("win_top_cnt", cnt_o, 1);
        wait_rx("win_top_rx_count", 1, 60);
        expect_byte("win_top_rx_byte", 8'h5A, 1'b0);
        wait_idle("win_top_idle", 20);

        // Overflow: six back-to-back writes into a four-entry FIFO
        wr(17'h1400, 8'h30, 1'b1);
        check("ovf_cnt1", cnt_o, 1);
        wr(17'h1400, 8'h31, 1'b1);
        check("ovf_cnt2", cnt_o, 1);
        wr(17'h1400, 8'h32, 1'b1);
        check("ovf_cnt3", cnt_o, 2);
        wr(17'h1400, 8'h33, 1'b1);
        check("ovf_cnt4", cnt_o, 3);
        check("ovf_full4", full_o, 0);
        wr(17'h1400, 8'h34, 1'b1);
        check("ovf_cnt5", cnt_o, 4);
        check("ovf_full5", full_o, 1);
        check("ovf_flag5", ovf_o, 0);
        wr(17'h1400, 8'h35, 1'b1);
        check("ovf_cnt6", cnt_o, 4);
        check("ovf_full6", full_o, 1);
        check("ovf_flag6", ovf_o, 1);
        wait_rx("ovf_rx_count", 5, 5 * (NBITS * DIV + 2) + 40);
        expect_byte("ovf_rx0", 8'h30, 1'b0);
        expect_byte("ovf_rx1", 8'h31, 1'b1);
        expect_byte("ovf_rx2", 8'h32, 1'b1);
        expect_byte("ovf_rx3", 8'h33, 1'b0);
        expect_byte("ovf_rx4", 8'h34, 1'b1);
        repeat (100) tick();
        check("ovf_no_sixth", rx_q.size(), 0);
        check("ovf_idle_busy", busy_o, 0);
        check("ovf_sticky", ovf_o, 1);

        // Reset during DATA bit 3 with one more byte queued
        wr(17'h1400, 8'hA5, 1'b1);
        wr(17'h1400, 8'h3C, 1'b1);
        check("mid_cnt_queued", cnt_o, 1);
        repeat (17) tick();
        check("mid_bit3", tx_o, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_tx", tx_o, 1);
        check("mid_rst_cnt", cnt_o, 0);
        check("mid_rst_ovf", ovf_o, 0);
        check("mid_rst_busy", busy_o, 0);
        rst = 1'b0;
        lows = 0;
        repeat (200) begin
            tick();
            if (tx_o !== 1'b1) lows++;
        end
        check("mid_no_frame_lows", lows, 0);
        check("mid_no_frame_rx", rx_q.size(), 0);

`ifdef EJ32_TX_PARITY_EN
        // Even parity bit
        wr(17'h1400, 8'h07, 1'b1);
        wait_rx("par07_rx_count", 1, 80);
        expect_byte("par07", 8'h07, 1'b1);
        wait_idle("par07_idle", 20);
        wr(17'h1400, 8'h03, 1'b1);
        wait_rx("par03_rx_count", 1, 80);
        expect_byte("par03", 8'h03, 1'b0);
        wait_idle("par03_idle", 20);
`endif

        check("frame_errors", frame_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
